ray_core_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer for up to 8 parallel ray-generator cores sharing one downstream ray consumer (intersection/shading stage). Launches all cores on a frame start, accepts one generated ray per cycle, forwards it with originating core ID and pixel index through a registered valid/ready port, and counts accepted rays to report frame completion.

---
 rtl/ray_core_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ray_core_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_core_arbiter.sv
// Round-robin arbiter and frame sequencer that funnels rays from NUM_CORES generator
// cores into a single registered valid/ready output and counts rays per frame.
module ray_core_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int DIR_W     = 32,
   parameter int IDX_W     = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [IDX_W-1:0]              pixel_count,
   output logic [NUM_CORES-1:0]          core_en,
   input  logic [NUM_CORES-1:0]          req_valid,
   input  logic [NUM_CORES*DIR_W-1:0]    req_dir_x,
   input  logic [NUM_CORES*DIR_W-1:0]    req_dir_y,
   input  logic [NUM_CORES*DIR_W-1:0]    req_dir_z,
   input  logic [NUM_CORES*IDX_W-1:0]    req_index,
   output logic [NUM_CORES-1:0]          req_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DIR_W-1:0]       out_dir_x,
   output logic signed [DIR_W-1:0]       out_dir_y,
   output logic signed [DIR_W-1:0]       out_dir_z,
   output logic [IDX_W-1:0]              out_index,
   output logic [2:0]                    out_core,
   output logic                          busy,
   output logic                          frame_done,
   output logic [IDX_W-1:0]              rays_accepted
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [NUM_CORES-1:0]    core_en_q;
   logic                    out_valid_q;
   logic [DIR_W-1:0]        out_dir_x_q;
   logic [DIR_W-1:0]        out_dir_y_q;
   logic [DIR_W-1:0]        out_dir_z_q;
   logic [IDX_W-1:0]        out_index_q;
   logic [2:0]              out_core_q;
   logic [IDX_W-1:0]        rays_q;
   logic [IDX_W-1:0]        pcount_q;
   logic [2:0]              rr_ptr_q;
   logic                    zero_done_q;

   logic [7:0]              valid_ext_s;
   logic [3:0]              cand_s;
   logic                    grant_found_s;
   logic [2:0]              grant_id_s;
   logic [7:0]              grant_onehot_s;
   logic                    slot_free_s;
   logic                    xfer_s;
   logic [2:0]              rr_ptr_d;
   logic [IDX_W-1:0]        rays_d;
   logic                    drain_done_s;

   // Round-robin search starting at rr_ptr; first valid core wins
   always_comb begin
      valid_ext_s   = 8'(req_valid);
      cand_s        = 4'd0;
      grant_found_s = 1'b0;
      grant_id_s    = 3'd0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand_s = {1'b0, rr_ptr_q} + 4'(k);
         if (cand_s >= 4'(NUM_CORES)) begin
            cand_s = cand_s - 4'(NUM_CORES);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_found_s && valid_ext_s[cand_s[2:0]]) begin
            grant_found_s = 1'b1;
            grant_id_s    = cand_s[2:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Acceptance strobe: only in RUN, only when the output slot is free this cycle
   always_comb begin
      slot_free_s    = !out_valid_q || out_ready;
      grant_onehot_s = 8'd1 << grant_id_s;
      if ((state_q == RUN) && slot_free_s && grant_found_s) begin
         req_ready = grant_onehot_s[NUM_CORES-1:0];
         xfer_s    = 1'b1;
      end else begin
         req_ready = '0;
         xfer_s    = 1'b0;
      end
   end

   // Next-pointer and count increment used by the sequencer on a transfer
   always_comb begin
      if (grant_id_s == 3'(NUM_CORES-1)) begin
         rr_ptr_d = 3'd0;
      end else begin
         rr_ptr_d = grant_id_s + 3'd1;
      end
      rays_d       = rays_q + IDX_W'(1);
      drain_done_s = (state_q == DRAIN) && (!out_valid_q || out_ready);
   end

   // Frame sequencer FSM together with the output register and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         core_en_q   <= '0;
         out_valid_q <= 1'b0;
         out_dir_x_q <= '0;
         out_dir_y_q <= '0;
         out_dir_z_q <= '0;
         out_index_q <= '0;
         out_core_q  <= 3'd0;
         rays_q      <= '0;
         pcount_q    <= '0;
         rr_ptr_q    <= 3'd0;
         zero_done_q <= 1'b0;
      end else begin
         core_en_q   <= '0;
         zero_done_q <= 1'b0;
         if (xfer_s) begin
            out_valid_q <= 1'b1;
            out_dir_x_q <= req_dir_x[int'(grant_id_s)*DIR_W +: DIR_W];
            out_dir_y_q <= req_dir_y[int'(grant_id_s)*DIR_W +: DIR_W];
            out_dir_z_q <= req_dir_z[int'(grant_id_s)*DIR_W +: DIR_W];
            out_index_q <= req_index[int'(grant_id_s)*IDX_W +: IDX_W];
            out_core_q  <= grant_id_s;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  pcount_q <= pixel_count;
                  rays_q   <= '0;
                  rr_ptr_q <= 3'd0;
                  // An empty frame completes immediately without waking the cores
                  if (pixel_count == '0) begin
                     zero_done_q <= 1'b1;
                  end else begin
                     core_en_q <= '1;
                     state_q   <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               state_q <= RUN;
            end
            RUN: begin
               if (xfer_s) begin
                  rays_q   <= rays_d;
                  rr_ptr_q <= rr_ptr_d;
                  if (rays_d == pcount_q) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_done_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // frame_done must coincide with the final output handshake, so it follows out_ready
   assign frame_done    = drain_done_s || zero_done_q;
   assign core_en       = core_en_q;
   assign out_valid     = out_valid_q;
   assign out_dir_x     = out_dir_x_q;
   assign out_dir_y     = out_dir_y_q;
   assign out_dir_z     = out_dir_z_q;
   assign out_index     = out_index_q;
   assign out_core      = out_core_q;
   assign busy          = (state_q != IDLE);
   assign rays_accepted = rays_q;

endmodule

// File: tb/tb_ray_core_arbiter.sv
// Directed bench for ray_core_arbiter: expected core IDs are queued with each stimulus,
// a negedge monitor pops and checks every output handshake.
module tb_ray_core_arbiter;

   localparam int NC = 4;
   localparam int DW = 32;
   localparam int IW = 32;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [IW-1:0]     pixel_count;
   logic [NC-1:0]     core_en;
   logic [NC-1:0]     req_valid;
   logic [NC*DW-1:0]  req_dir_x;
   logic [NC*DW-1:0]  req_dir_y;
   logic [NC*DW-1:0]  req_dir_z;
   logic [NC*IW-1:0]  req_index;
   logic [NC-1:0]     req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_dir_x;
   logic [DW-1:0]     out_dir_y;
   logic [DW-1:0]     out_dir_z;
   logic [IW-1:0]     out_index;
   logic [2:0]        out_core;
   logic              busy;
   logic              frame_done;
   logic [IW-1:0]     rays_accepted;

   int nchk = 0;
   int nerr = 0;
   int en_pulses = 0;
   int bad02 = 0;
   int exp_core_q[$];

   ray_core_arbiter #(.NUM_CORES(NC), .DIR_W(DW), .IDX_W(IW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .pixel_count(pixel_count),
      .core_en(core_en), .req_valid(req_valid), .req_dir_x(req_dir_x),
      .req_dir_y(req_dir_y), .req_dir_z(req_dir_z), .req_index(req_index),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_dir_x(out_dir_x), .out_dir_y(out_dir_y), .out_dir_z(out_dir_z),
      .out_index(out_index), .out_core(out_core), .busy(busy),
      .frame_done(frame_done), .rays_accepted(rays_accepted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_idx(int k);
      return 32'(32'h28 + k);
   endfunction

   function automatic logic [95:0] exp_dir(int k);
      return {32'(-(k + 1)), 32'(k * 3), 32'(32'h1000 + k)};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_msg(string name);
      nchk++;
      nerr++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!frame_done && cyc < 60);
      if (!frame_done) fail_msg("frame_done_timeout");
   endtask

   task automatic wait_rays(int n);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (rays_accepted != IW'(n) && c < 60);
      if (rays_accepted != IW'(n)) fail_msg("rays_timeout");
   endtask

   // Scoreboard monitor: every handshake is compared against the queued core ID
   always @(negedge clk) begin
      if (reset_n) begin
         if (core_en != '0) en_pulses++;
         if (req_ready[0] || req_ready[2]) bad02++;
         if (out_valid && out_ready) begin
            if (exp_core_q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL sb_unexpected: got core %0d expected none", out_core);
            end else begin
               int e;
               e = exp_core_q.pop_front();
               check("sb_core", 128'(out_core), 128'(e));
               check("sb_index", 128'(out_index), 128'(exp_idx(e)));
               check("sb_dir", 128'({out_dir_x, out_dir_y, out_dir_z}), 128'(exp_dir(e)));
            end
         end
      end
   end

   initial begin
      int cyc;
      int en0;
      reset_n = 1'b0;
      start = 1'b0;
      pixel_count = '0;
      req_valid = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < NC; k++) begin
         req_dir_x[k*DW +: DW] = 32'(-(k + 1));
         req_dir_y[k*DW +: DW] = 32'(k * 3);
         req_dir_z[k*DW +: DW] = 32'(32'h1000 + k);
         req_index[k*IW +: IW] = exp_idx(k);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_core_en", 128'(core_en), 128'd0);
      check("rst_req_ready", 128'(req_ready), 128'd0);
      check("rst_frame_done", 128'(frame_done), 128'd0);
      check("rst_rays", 128'(rays_accepted), 128'd0);
      check("rst_out_idx_core", 128'({out_index, out_core}), 128'd0);

      // Test 1: all cores valid, 8 rays at full throughput
      tick();
      start = 1'b1; pixel_count = 32'd8;
      for (int k = 0; k < 8; k++) exp_core_q.push_back(k % 4);
      @(negedge clk);
      check("t1_idle_core_en", 128'(core_en), 128'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("t1_launch_core_en", 128'(core_en), 128'hF);
      check("t1_launch_busy", 128'(busy), 128'd1);
      wait_done(cyc);
      check("t1_done_latency", 128'(cyc), 128'd9);
      check("t1_done_with_hs", 128'(out_valid), 128'd1);
      tick();
      @(negedge clk);
      check("t1_busy_fall", 128'(busy), 128'd0);
      check("t1_done_pulse", 128'(frame_done), 128'd0);
      check("t1_rays", 128'(rays_accepted), 128'd8);
      check("t1_sb_empty", 128'(exp_core_q.size()), 128'd0);

      // Test 2: only cores 1 and 3 request
      tick();
      req_valid = 4'b1010; start = 1'b1; pixel_count = 32'd4;
      bad02 = 0;
      exp_core_q.push_back(1); exp_core_q.push_back(3);
      exp_core_q.push_back(1); exp_core_q.push_back(3);
      tick();
      start = 1'b0;
      wait_done(cyc);
      tick();
      @(negedge clk);
      check("t2_ready_02", 128'(bad02), 128'd0);
      check("t2_rays", 128'(rays_accepted), 128'd4);
      check("t2_sb_empty", 128'(exp_core_q.size()), 128'd0);

      // Test 3: output stall with core 2's ray (index 0x2A) in the register
      tick();
      req_valid = 4'b0100; out_ready = 1'b0; start = 1'b1; pixel_count = 32'd3;
      for (int k = 0; k < 3; k++) exp_core_q.push_back(2);
      tick();
      start = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 20);
      if (!out_valid) fail_msg("t3_valid_timeout");
      for (int i = 0; i < 5; i++) begin
         check("t3_stall_valid", 128'(out_valid), 128'd1);
         check("t3_stall_index", 128'(out_index), 128'h2A);
         check("t3_stall_ready", 128'(req_ready), 128'd0);
         check("t3_stall_rays", 128'(rays_accepted), 128'd1);
         if (i < 4) @(negedge clk);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_release_ready", 128'(req_ready), 128'h4);
      @(negedge clk);
      check("t3_reload_valid", 128'(out_valid), 128'd1);
      check("t3_reload_rays", 128'(rays_accepted), 128'd2);
      wait_done(cyc);
      tick();
      @(negedge clk);
      check("t3_rays", 128'(rays_accepted), 128'd3);
      check("t3_sb_empty", 128'(exp_core_q.size()), 128'd0);

      // Test 4: empty frame
      en0 = en_pulses;
      tick();
      start = 1'b1; pixel_count = 32'd0;
      @(negedge clk);
      check("t4_done_early", 128'(frame_done), 128'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("t4_done", 128'(frame_done), 128'd1);
      check("t4_busy", 128'(busy), 128'd0);
      tick();
      @(negedge clk);
      check("t4_done_one", 128'(frame_done), 128'd0);
      check("t4_busy2", 128'(busy), 128'd0);
      check("t4_no_en", 128'(en_pulses - en0), 128'd0);

      // Test 5: reset during RUN after three rays, then a short frame
      tick();
      req_valid = 4'hF; start = 1'b1; pixel_count = 32'd8;
      exp_core_q.push_back(0); exp_core_q.push_back(1); exp_core_q.push_back(2);
      tick();
      start = 1'b0;
      wait_rays(3);
      #1;
      reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 128'(out_valid), 128'd0);
      check("t5_rst_busy", 128'(busy), 128'd0);
      check("t5_rst_rays", 128'(rays_accepted), 128'd0);
      check("t5_rst_ready", 128'(req_ready), 128'd0);
      check("t5_rst_out", 128'({out_index, out_core, out_dir_x}), 128'd0);
      check("t5_sb_empty_rst", 128'(exp_core_q.size()), 128'd0);
      tick();
      reset_n = 1'b1;
      tick();
      start = 1'b1; pixel_count = 32'd2;
      exp_core_q.push_back(0); exp_core_q.push_back(1);
      tick();
      start = 1'b0;
      wait_done(cyc);
      tick();
      @(negedge clk);
      check("t5_rays", 128'(rays_accepted), 128'd2);
      check("t5_sb_empty", 128'(exp_core_q.size()), 128'd0);

      // Test 6: second start while busy is ignored
      en0 = en_pulses;
      tick();
      start = 1'b1; pixel_count = 32'd6;
      for (int k = 0; k < 6; k++) exp_core_q.push_back(k % 4);
      tick();
      start = 1'b0;
      wait_rays(2);
      tick();
      start = 1'b1; pixel_count = 32'd1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      tick();
      @(negedge clk);
      check("t6_rays", 128'(rays_accepted), 128'd6);
      check("t6_one_launch", 128'(en_pulses - en0), 128'd1);
      check("t6_sb_empty", 128'(exp_core_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
